dm9000a_bus_controller: RTL and testbench

Executes one DM9000A host-bus command per start pulse: the command fields come from the ethernet controller arbitrator's `enet_*` outputs. Each command is one or two timed bus cycles on the chip's 16-bit interface (CMD, CS#, IOR#, IOW#, data bus), followed by an optional post-command delay. The block returns read data and a one-cycle `done` pulse to whichever client currently holds the grant. It sits directly downstream of the arbitrator and is the only block that drives the chip pins.

---
 rtl/dm9000a_bus_controller.sv | 177 +++++++++++++++++
 tb/tb_dm9000a_bus_controller.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/dm9000a_bus_controller.sv
// DM9000A host-bus sequencer: runs one register or data-port command per start pulse
// as one or two timed CS#/IOR#/IOW# cycles, then an optional settle delay.
module dm9000a_bus_controller #(
    parameter int SETUP_CYCLES      = 1,
    parameter int STROBE_CYCLES     = 2,
    parameter int STD_DELAY_CYCLES  = 4,
    parameter int LONG_DELAY_CYCLES = 200
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        start_command_in,
    input  logic [1:0]  command_type_in,
    input  logic [7:0]  addr_in,
    input  logic [15:0] dataw_in,
    input  logic [2:0]  post_command_delay_in,
    output logic        busy_out,
    output logic        done_out,
    output logic [15:0] rdata_out,
    output logic        enet_cmd_out,
    output logic        enet_cs_n_out,
    output logic        enet_ior_n_out,
    output logic        enet_iow_n_out,
    output logic [15:0] enet_data_out,
    output logic        enet_data_oe_out,
    input  logic [15:0] enet_data_in
);

    // state  | meaning
    // IDLE   | waiting for a start pulse
    // SETUP  | CS#/CMD/data valid, strobe still high
    // STROBE | IOR# or IOW# low
    // HOLD   | strobe released, CS#/CMD/data still driven
    // GAP    | one idle cycle between index and data cycles
    // DELAY  | post-command settle time
    // DONE   | one-cycle completion pulse
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETUP  = 3'd1;
    localparam logic [2:0] ST_STROBE = 3'd2;
    localparam logic [2:0] ST_HOLD   = 3'd3;
    localparam logic [2:0] ST_GAP    = 3'd4;
    localparam logic [2:0] ST_DELAY  = 3'd5;
    localparam logic [2:0] ST_DONE   = 3'd6;

    localparam int MAX_BUS = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
    localparam int MAX_DLY = (STD_DELAY_CYCLES > LONG_DELAY_CYCLES) ? STD_DELAY_CYCLES : LONG_DELAY_CYCLES;
    localparam int MAX_CYC = (MAX_BUS > MAX_DLY) ? MAX_BUS : MAX_DLY;
    localparam int CW      = $clog2(MAX_CYC + 1);

    localparam logic [CW-1:0] LD_SETUP  = CW'(SETUP_CYCLES - 1);
    localparam logic [CW-1:0] LD_STROBE = CW'(STROBE_CYCLES - 1);
    localparam logic [CW-1:0] LD_STD    = CW'(STD_DELAY_CYCLES - 1);
    localparam logic [CW-1:0] LD_LONG   = CW'(LONG_DELAY_CYCLES - 1);

    logic [2:0]    state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          phase, phase_n;   // 0 = index-port cycle, 1 = data-port cycle
    logic [1:0]    cmd_type, cmd_type_n;
    logic [7:0]    addr, addr_n;
    logic [15:0]   dataw, dataw_n;
    logic [2:0]    delay_code, delay_code_n;
    logic          capture;
    logic          bus_n, wr_n;

    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        phase_n      = phase;
        cmd_type_n   = cmd_type;
        addr_n       = addr;
        dataw_n      = dataw;
        delay_code_n = delay_code;
        capture      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_command_in) begin
                    cmd_type_n   = command_type_in;
                    addr_n       = addr_in;
                    dataw_n      = dataw_in;
                    delay_code_n = post_command_delay_in;
                    phase_n      = command_type_in[1];
                    cnt_n        = LD_SETUP;
                    state_n      = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt == '0) begin
                    cnt_n   = LD_STROBE;
                    state_n = ST_STROBE;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            ST_STROBE: begin
                if (cnt == '0) begin
                    capture = phase & cmd_type[0];
                    state_n = ST_HOLD;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            ST_HOLD: begin
                if (!phase) begin
                    state_n = ST_GAP;
                end else if (delay_code == 3'd1) begin
                    cnt_n   = LD_STD;
                    state_n = ST_DELAY;
                end else if (delay_code == 3'd2) begin
                    cnt_n   = LD_LONG;
                    state_n = ST_DELAY;
                end else begin
                    state_n = ST_DONE;
                end
            end
            ST_GAP: begin
                phase_n = 1'b1;
                cnt_n   = LD_SETUP;
                state_n = ST_SETUP;
            end
            ST_DELAY: begin
                if (cnt == '0) begin
                    state_n = ST_DONE;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            ST_DONE:  state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase
    end

    // Pins are registered from the next-state view so every strobe edge comes from a flop.
    assign bus_n = (state_n == ST_SETUP) || (state_n == ST_STROBE) || (state_n == ST_HOLD);
    assign wr_n  = !phase_n || !cmd_type_n[0];

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state            <= ST_IDLE;
            cnt              <= '0;
            phase            <= 1'b0;
            cmd_type         <= 2'd0;
            addr             <= 8'h00;
            dataw            <= 16'h0000;
            delay_code       <= 3'd0;
            busy_out         <= 1'b0;
            done_out         <= 1'b0;
            rdata_out        <= 16'h0000;
            enet_cmd_out     <= 1'b0;
            enet_cs_n_out    <= 1'b1;
            enet_ior_n_out   <= 1'b1;
            enet_iow_n_out   <= 1'b1;
            enet_data_out    <= 16'h0000;
            enet_data_oe_out <= 1'b0;
        end else begin
            state            <= state_n;
            cnt              <= cnt_n;
            phase            <= phase_n;
            cmd_type         <= cmd_type_n;
            addr             <= addr_n;
            dataw            <= dataw_n;
            delay_code       <= delay_code_n;
            busy_out         <= (state_n != ST_IDLE);
            done_out         <= (state_n == ST_DONE);
            enet_cs_n_out    <= !bus_n;
            enet_ior_n_out   <= !((state_n == ST_STROBE) && !wr_n);
            enet_iow_n_out   <= !((state_n == ST_STROBE) && wr_n);
            enet_data_oe_out <= bus_n && wr_n;
            if (bus_n) begin
                enet_cmd_out  <= phase_n;
                enet_data_out <= phase_n ? dataw_n : {8'h00, addr_n};
            end
            if (capture) begin
                rdata_out <= enet_data_in;
            end
        end
    end

endmodule

// File: tb/tb_dm9000a_bus_controller.sv
// Bench for dm9000a_bus_controller: builds the expected per-cycle pin trace of each
// command from the bus-cycle rules and compares it against the DUT every cycle.
module tb_dm9000a_bus_controller;

    localparam int S    = 1;
    localparam int T    = 2;
    localparam int STD  = 4;
    localparam int LONG = 200;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        start_command_in = 1'b0;
    logic [1:0]  command_type_in = 2'd0;
    logic [7:0]  addr_in = 8'h00;
    logic [15:0] dataw_in = 16'h0000;
    logic [2:0]  post_command_delay_in = 3'd0;
    logic        busy_out, done_out;
    logic [15:0] rdata_out;
    logic        enet_cmd_out, enet_cs_n_out, enet_ior_n_out, enet_iow_n_out;
    logic [15:0] enet_data_out;
    logic        enet_data_oe_out;
    logic [15:0] enet_data_in;
    logic [15:0] bus_rd_val = 16'h0000;

    int checks = 0;
    int errors = 0;
    logic [15:0] model_rdata = 16'h0000;

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        cs_n;
        logic        ior_n;
        logic        iow_n;
        logic        oe;
        logic        cmd;
        logic [15:0] data;
    } pins_t;

    pins_t exp_q[$];

    always #5 Clock = ~Clock;

    // Chip model: drives read data only while IOR# is low.
    assign enet_data_in = enet_ior_n_out ? 16'hDEAD : bus_rd_val;

    dm9000a_bus_controller #(
        .SETUP_CYCLES(S), .STROBE_CYCLES(T),
        .STD_DELAY_CYCLES(STD), .LONG_DELAY_CYCLES(LONG)
    ) dut (
        .Clock(Clock), .Reset(Reset),
        .start_command_in(start_command_in), .command_type_in(command_type_in),
        .addr_in(addr_in), .dataw_in(dataw_in), .post_command_delay_in(post_command_delay_in),
        .busy_out(busy_out), .done_out(done_out), .rdata_out(rdata_out),
        .enet_cmd_out(enet_cmd_out), .enet_cs_n_out(enet_cs_n_out),
        .enet_ior_n_out(enet_ior_n_out), .enet_iow_n_out(enet_iow_n_out),
        .enet_data_out(enet_data_out), .enet_data_oe_out(enet_data_oe_out),
        .enet_data_in(enet_data_in)
    );

    function automatic pins_t mk(input logic busy, input logic done, input logic cs_n,
                                 input logic ior_n, input logic iow_n, input logic oe,
                                 input logic cmd, input logic [15:0] data);
        pins_t p;
        p.busy = busy; p.done = done; p.cs_n = cs_n; p.ior_n = ior_n;
        p.iow_n = iow_n; p.oe = oe; p.cmd = cmd; p.data = data;
        return p;
    endfunction

    // Expected trace: entry i is cycle i+1 after the start edge; last entry is the idle cycle.
    task automatic build_trace(input logic [1:0] t, input logic [7:0] a, input logic [15:0] w,
                               input logic [2:0] code);
        int k, d;
        logic cmd, wr;
        logic [15:0] data;
        exp_q.delete();
        k = (t < 2) ? 2 : 1;
        d = (code == 3'd1) ? STD : (code == 3'd2) ? LONG : 0;
        for (int b = 0; b < k; b++) begin
            cmd  = !(k == 2 && b == 0);
            wr   = (cmd == 1'b0) || (t == 2'd0) || (t == 2'd2);
            data = cmd ? w : {8'h00, a};
            if (b == 1) exp_q.push_back(mk(1, 0, 1, 1, 1, 0, 0, 16'h0));
            for (int i = 0; i < S; i++) exp_q.push_back(mk(1, 0, 0, 1, 1, wr, cmd, data));
            for (int i = 0; i < T; i++) exp_q.push_back(mk(1, 0, 0, wr, !wr, wr, cmd, data));
            exp_q.push_back(mk(1, 0, 0, 1, 1, wr, cmd, data));
        end
        for (int i = 0; i < d; i++) exp_q.push_back(mk(1, 0, 1, 1, 1, 0, 0, 16'h0));
        exp_q.push_back(mk(1, 1, 1, 1, 1, 0, 0, 16'h0));
        exp_q.push_back(mk(0, 0, 1, 1, 1, 0, 0, 16'h0));
    endtask

    // Issue one command at the current negedge and check every cycle through the idle cycle.
    task automatic run_cmd(input string name, input logic [1:0] t, input logic [7:0] a,
                           input logic [15:0] w, input logic [2:0] code, input logic [15:0] rv,
                           input int restart_cycle);
        pins_t act, exp;
        int n;
        build_trace(t, a, w, code);
        n = exp_q.size();
        if (t[0]) model_rdata = rv;
        bus_rd_val            = rv;
        start_command_in      = 1'b1;
        command_type_in       = t;
        addr_in               = a;
        dataw_in              = w;
        post_command_delay_in = code;
        @(negedge Clock);
        for (int c = 1; c <= n; c++) begin
            if (c == 1) begin
                start_command_in      = 1'b0;
                command_type_in       = 2'($urandom);
                addr_in               = ~a;
                dataw_in              = ~w;
                post_command_delay_in = 3'($urandom);
            end
            if (c == restart_cycle) begin
                start_command_in      = 1'b1;
                command_type_in       = 2'($urandom);
                post_command_delay_in = 3'd2;
            end
            if (c == restart_cycle + 1) start_command_in = 1'b0;
            exp = exp_q[c-1];
            act = {busy_out, done_out, enet_cs_n_out, enet_ior_n_out, enet_iow_n_out,
                   enet_data_oe_out, enet_cmd_out, enet_data_out};
            if (exp.cs_n) act.cmd = exp.cmd;
            if (!exp.oe) act.data = exp.data;
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL %s cycle %0d pins got %h want %h", name, c, act, exp);
            end
            if (exp.done || c == n) begin
                checks++;
                if (rdata_out !== model_rdata) begin
                    errors++;
                    $display("FAIL %s rdata cycle %0d got %h want %h", name, c, rdata_out, model_rdata);
                end
            end
            if (c < n) @(negedge Clock);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (3) @(negedge Clock);
        checks++;
        if ({busy_out, done_out, enet_cs_n_out, enet_ior_n_out, enet_iow_n_out,
             enet_data_oe_out, enet_cmd_out, enet_data_out, rdata_out} !== {7'b0011100, 32'h0}) begin
            errors++;
            $display("FAIL reset_state got busy%b done%b cs%b ior%b iow%b oe%b cmd%b d%h r%h want idle zeros",
                     busy_out, done_out, enet_cs_n_out, enet_ior_n_out, enet_iow_n_out,
                     enet_data_oe_out, enet_cmd_out, enet_data_out, rdata_out);
        end
        Reset = 1'b0;
        @(negedge Clock);
    endtask

    task automatic test_reg_write();
        run_cmd("reg_write", 2'd0, 8'h1F, 16'h0001, 3'd0, 16'h0000, 0);
    endtask

    task automatic test_reg_read();
        run_cmd("reg_read", 2'd1, 8'h28, 16'h5555, 3'd0, 16'h0A46, 0);
        run_cmd("rdata_hold", 2'd2, 8'h00, 16'hBEEF, 3'd0, 16'h0000, 0);
    endtask

    task automatic test_long_delay();
        run_cmd("data_read_long", 2'd3, 8'h00, 16'h0000, 3'd2, 16'hC3A5, 0);
    endtask

    task automatic test_ignored_start();
        run_cmd("ignored_start", 2'd2, 8'h00, 16'h7E81, 3'd5, 16'h0000, 2);
    endtask

    task automatic test_latch();
        run_cmd("latch_dataw", 2'd0, 8'h05, 16'h1234, 3'd0, 16'h0000, 0);
    endtask

    task automatic test_reset_abort();
        logic saw_done;
        start_command_in = 1'b1;
        command_type_in  = 2'd0;
        addr_in          = 8'h10;
        dataw_in         = 16'hA5A5;
        post_command_delay_in = 3'd0;
        @(negedge Clock);
        start_command_in = 1'b0;
        @(negedge Clock);
        @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        checks++;
        if ({enet_cs_n_out, enet_ior_n_out, enet_iow_n_out, enet_data_oe_out, busy_out, rdata_out}
            !== {5'b11100, 16'h0}) begin
            errors++;
            $display("FAIL reset_abort cycle4 got cs%b ior%b iow%b oe%b busy%b rdata%h want 1 1 1 0 0 0000",
                     enet_cs_n_out, enet_ior_n_out, enet_iow_n_out, enet_data_oe_out, busy_out, rdata_out);
        end
        Reset = 1'b0;
        model_rdata = 16'h0000;
        saw_done = 1'b0;
        repeat (20) begin
            @(negedge Clock);
            if (done_out !== 1'b0 || busy_out !== 1'b0) saw_done = 1'b1;
        end
        checks++;
        if (saw_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_abort_no_done got activity %b want 0", saw_done);
        end
    endtask

    // Random commands issued back to back: each start lands in the cycle after DONE.
    task automatic test_back_to_back();
        logic [2:0] code;
        for (int i = 0; i < 25; i++) begin
            code = 3'($urandom_range(0, 7));
            if (code == 3'd2 && ($urandom_range(0, 3) != 0)) code = 3'd1;
            run_cmd("random", 2'($urandom), 8'($urandom), 16'($urandom), code,
                    16'($urandom), (i % 3 == 0) ? 2 : 0);
        end
    endtask

    initial begin
        test_reset();
        test_reg_write();
        test_reg_read();
        test_long_delay();
        test_ignored_start();
        test_latch();
        test_reg_read();
        test_reset_abort();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
